sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
- Serial-in, parallel-out deserializer; receive-side counterpart of the team's parallel-load serial shifter.
- Collects WIDTH bits MSB-first, one bit per enabled clock.
- Presents each completed word on a valid/ready output port.
- Sits between a serial link and any parallel consumer; a sticky flag reports overrun.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- sin  input  1  serial data bit, MSB of word first
- sen  input  1  shift enable; sin is sampled only on edges where sen=1
- clr  input  1  synchronous clear of partial word and overrun flag
- pdata  output  WIDTH  completed parallel word
- pvalid  output  1  pdata holds an unconsumed word
- pready  input  1  consumer accepts pdata on an edge where pvalid=1 and pready=1
- overrun  output  1  sticky: a completed word was dropped
- perr  output  1  parity error for the word on pdata; constant 0 unless SIPO_PARITY_EN

Behaviour:
- Reset:
  - rst=1 clears immediately, without waiting for clk: shift register sr=0, bit counter cnt=0, pdata=0, pvalid=0, overrun=0, perr=0.
  - Reset mid-word discards the partial word; the next bit after release is treated as the MSB.
- Shift:
  - Edge with sen=1 and clr=0: sr <= {sr[WIDTH-2:0], sin}; cnt <= cnt+1.
  - sen=0: sr and cnt hold. Gaps between bits are allowed.
- Word complete: edge with sen=1 and cnt==WIDTH-1 (the last bit).
  - cnt wraps to 0.
  - Candidate word = {sr[WIDTH-2:0], sin}.
  - Latency: pvalid is high in the cycle immediately after the edge that samples the last bit.
- Output holding register, two states:
  - EMPTY (pvalid=0): on word complete, pdata <= candidate; go to FULL.
  - FULL (pvalid=1): pdata and perr are stable. Accept edge (pready=1) with no word complete: go to EMPTY; pdata keeps its last value.
  - FULL, accept edge and word complete on the same edge: load the new word and stay FULL; no overrun.
  - FULL, pready=0 and word complete: drop the new word; pdata unchanged; overrun <= 1.
- overrun is sticky. Only rst or clr clears it.
- clr:
  - Takes priority over sen on the same edge.
  - Clears sr, cnt and overrun.
  - Does not touch pdata, pvalid or perr; a pending word survives.
- pready while EMPTY is ignored.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Frame = WIDTH data bits followed by one even-parity bit; cnt runs 0..WIDTH.
  - The parity bit is not shifted into sr; data is fully collected after the WIDTH-th data bit.
  - Word complete happens on the parity-bit edge, and the latency rule applies to that edge.
  - perr = XOR of all WIDTH+1 received bits; 1 means error.
  - perr loads together with pdata and is held alongside it.
  - On overrun, the dropped word's perr is discarded.
- Undefined:
  - Frame = WIDTH bits; perr is tied to 0; no extra counter state.

Test Plan (WIDTH=4):
- Mid-word reset: rst pulse after 2 bits, then bits 1,0,1,1 with pready=1 → pdata=4'b1011, pvalid high for exactly 1 cycle after the 4th-bit edge; all outputs were 0 during rst.
- Gapped input: bits 0,1,1,0 with sen=0 for 3 cycles between each bit (sin toggling while sen=0) → pdata=4'b0110, pvalid after the 4th enabled edge only.
- Overrun: pready=0, send 1011 then 0110 → pdata stays 4'b1011, overrun=1; then pready=1 → pvalid falls next cycle, overrun stays 1 until clr.
- Back-to-back with simultaneous accept: pready=1 exactly on the last-bit edge of word 2 (1011 then 0110) → pdata 1011 then 0110, pvalid continuous, overrun=0.
- clr: after bits 1,1, assert clr (with sen=1), then send 0,1,0,1 → pdata=4'b0101, overrun cleared; a pending pvalid word is unchanged by clr.
- SIPO_PARITY_EN: frame 1,0,1,1,parity 1 → pdata=1011, perr=0; frame 1,0,1,1,parity 0 → perr=1; pvalid follows the 5th edge.

Source files
------------

// File: rtl/sipo_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sipo_deser : MSB-first serial-in/parallel-out deserializer, valid/ready    |
// | output, sticky overrun. Define SIPO_PARITY_EN for even-parity framing.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sipo_deser #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sen,
   input  logic             clr,
   output logic [WIDTH-1:0] pdata,
   output logic             pvalid,
   input  logic             pready,
   output logic             overrun,
   output logic             perr
);

`ifdef SIPO_PARITY_EN
   localparam int LAST = WIDTH;
   localparam int SRW  = WIDTH;
`else
   // The last data bit goes straight from sin into pdata, so sr needs one bit less.
   localparam int LAST = WIDTH - 1;
   localparam int SRW  = WIDTH - 1;
`endif
   localparam int CW = $clog2(LAST + 1);
   localparam logic [CW-1:0] LAST_C = CW'(LAST);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [SRW-1:0]   sr;
   logic [SRW-1:0]   sr_nxt;
   logic [CW-1:0]    cnt;
   logic             step;
   logic             done;
   logic             shift;
   logic             load;
   logic             drop;
   logic [WIDTH-1:0] cand;
   logic             cand_perr;

   assign step = sen && !clr;
   assign done = step && (cnt == LAST_C);

`ifdef SIPO_PARITY_EN
   // Parity bit only closes the frame; it never enters sr.
   assign shift     = step && !done;
   assign sr_nxt    = {sr[SRW-2:0], sin};
   assign cand      = sr;
   assign cand_perr = ^{sr, sin};
`else
   assign shift     = step;
   assign cand      = {sr, sin};
   assign sr_nxt    = cand[SRW-1:0];
   assign cand_perr = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (clr) begin
         sr  <= '0;
         cnt <= '0;
      end else if (step) begin
         if (shift) begin
            sr <= sr_nxt;
         end
         cnt <= done ? '0 : cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      drop      = 1'b0;
      case (state)
         EMPTY: begin
            if (done) begin
               load      = 1'b1;
               state_nxt = FULL;
            end
         end
         FULL: begin
            if (pready) begin
               if (done) begin
                  load = 1'b1;
               end else begin
                  state_nxt = EMPTY;
               end
            end else if (done) begin
               drop = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pdata <= '0;
         perr  <= 1'b0;
      end else if (load) begin
         pdata <= cand;
         perr  <= cand_perr;
      end
   end

   // done is never true with clr, so clear and set cannot collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (clr) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end
   end

   assign pvalid = (state == FULL);

endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sipo_deser : scoreboard bench for sipo_deser (WIDTH=4), directed       |
// | scenarios followed by random traffic. Honours SIPO_PARITY_EN.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sipo_deser;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sin = 1'b0;
   logic         sen = 1'b0;
   logic         clr = 1'b0;
   logic         pready = 1'b0;
   logic [W-1:0] pdata;
   logic         pvalid;
   logic         overrun;
   logic         perr;

   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;

   // reference model state
   int unsigned m_acc = 0;
   int          m_nbits = 0;
   bit          m_par = 1'b0;
   bit          m_full = 1'b0;
   bit          m_ovr = 1'b0;
   logic [W-1:0] q_d[$];
   logic         q_p[$];

   sipo_deser #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .sin(sin), .sen(sen), .clr(clr),
      .pdata(pdata), .pvalid(pvalid), .pready(pready),
      .overrun(overrun), .perr(perr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_nbits = 0; m_par = 1'b0; m_full = 1'b0; m_ovr = 1'b0;
      q_d.delete(); q_p.delete();
   endtask

   // Effect of one clock edge, given the inputs held across it.
   task automatic model_edge(input logic s, input logic e, input logic c, input logic r);
      bit           accepted;
      bit           comp;
      logic [W-1:0] cw;
      logic         cp;
      accepted = m_full && r;
      comp = 1'b0;
      cw = '0;
      cp = 1'b0;
      if (c) begin
         m_nbits = 0; m_acc = 0; m_par = 1'b0; m_ovr = 1'b0;
      end else if (e) begin
`ifdef SIPO_PARITY_EN
         if (m_nbits == W) begin
            comp = 1'b1; cw = m_acc[W-1:0]; cp = m_par ^ s;
            m_nbits = 0; m_acc = 0; m_par = 1'b0;
         end else begin
            m_acc = m_acc * 2 + s; m_par = m_par ^ s; m_nbits++;
         end
`else
         m_acc = m_acc * 2 + s; m_nbits++;
         if (m_nbits == W) begin
            comp = 1'b1; cw = m_acc[W-1:0]; cp = 1'b0;
            m_nbits = 0; m_acc = 0;
         end
`endif
      end
      if (comp) begin
         if (!m_full || accepted) begin
            q_d.push_back(cw); q_p.push_back(cp); m_full = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (accepted) begin
         m_full = 1'b0;
      end
   endtask

   task automatic cycle(input logic s, input logic e, input logic c, input logic r);
      sin = s; sen = e; clr = c; pready = r;
      @(posedge clk); #1;
      model_edge(s, e, c, r);
   endtask

   // One frame, MSB first, 'gap' idle cycles before each bit (sin toggling).
   task automatic send_word(input logic [W-1:0] w, input int gap,
                            input logic rdy_rest, input logic rdy_last);
      int nb;
      logic [W:0] fr;
`ifdef SIPO_PARITY_EN
      nb = W + 1;
      fr = {w, ^w};
`else
      nb = W;
      fr = {1'b0, w};
`endif
      for (int i = nb - 1; i >= 0; i--) begin
         for (int g = 0; g < gap; g++) cycle(g[0], 1'b0, 1'b0, rdy_rest);
         cycle(fr[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy_rest);
      end
   endtask

   task automatic do_reset();
      sen = 1'b0; clr = 1'b0; pready = 1'b0;
      rst = 1'b1; #1;
      chk("rst_pdata", 32'(pdata), 0);
      chk("rst_pvalid", 32'(pvalid), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_perr", 32'(perr), 0);
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Monitor: per-cycle status against the model; words popped on accept.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         chk("pvalid", 32'(pvalid), 32'(m_full));
         chk("overrun", 32'(overrun), 32'(m_ovr));
         if (pvalid && pready) begin
            if (q_d.size() == 0) begin
               chk("unexpected_word", 32'(pdata), 32'hFFFF_FFFF);
            end else begin
               chk("pdata", 32'(pdata), 32'(q_d.pop_front()));
               chk("perr", 32'(perr), 32'(q_p.pop_front()));
            end
         end
      end
   end

   initial begin
      @(posedge clk); #1;
      do_reset();
      mon_en = 1'b1;

      // Mid-word reset with a pending word and two stray bits
      send_word(4'b1001, 0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      do_reset();
      send_word(4'b1011, 0, 1'b1, 1'b1);
      chk("midrst_pdata", 32'(pdata), 32'hB);
      chk("midrst_valid", 32'(pvalid), 1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // Gapped input
      send_word(4'b0110, 3, 1'b0, 1'b0);
      chk("gap_pdata", 32'(pdata), 32'h6);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // Overrun
      send_word(4'b1011, 0, 1'b0, 1'b0);
      send_word(4'b0110, 0, 1'b0, 1'b0);
      chk("ovr_pdata", 32'(pdata), 32'hB);
      chk("ovr_flag", 32'(overrun), 1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovr_sticky", 32'(overrun), 1);

      // clr with a pending word
      send_word(4'b1001, 0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      chk("clr_keep_pdata", 32'(pdata), 32'h9);
      chk("clr_overrun", 32'(overrun), 0);
      send_word(4'b0101, 0, 1'b1, 1'b1);
      chk("clr_pdata", 32'(pdata), 32'h5);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back, accept exactly on the last edge of word 2
      send_word(4'b1011, 0, 1'b0, 1'b0);
      send_word(4'b0110, 0, 1'b0, 1'b1);
      chk("b2b_pdata", 32'(pdata), 32'h6);
      chk("b2b_overrun", 32'(overrun), 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
      for (int i = 0; i < 5; i++) cycle(i[0], 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      begin
         logic [4:0] f1;
         logic [4:0] f2;
         f1 = 5'b10111;
         f2 = 5'b10110;
         cycle(1'b0, 1'b1, 1'b1, 1'b0);
         for (int i = 4; i >= 0; i--) cycle(f1[i], 1'b1, 1'b0, 1'b0);
         chk("par_ok_pdata", 32'(pdata), 32'hB);
         chk("par_ok_perr", 32'(perr), 0);
         cycle(1'b0, 1'b0, 1'b0, 1'b1);
         for (int i = 4; i >= 0; i--) cycle(f2[i], 1'b1, 1'b0, 1'b0);
         chk("par_bad_perr", 32'(perr), 1);
         cycle(1'b0, 1'b0, 1'b0, 1'b1);
      end
`endif

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 999) == 0) begin
            do_reset();
         end else begin
            cycle(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 1)));
         end
      end

      for (int n = 0; n < 4; n++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("drain_empty", 32'(q_d.size()), 0);
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
